pin_serializer: RTL and testbench
=================================

PIN_SERIALIZER -- requirements
Module: pin_serializer

Interface
REQ-001 Parameter ROM_AW, 7, ROM address width in bits.
REQ-002 Parameter SRAM_AW, 10, SRAM address width in bits.
REQ-003 Parameter DW, 8, SRAM write-data width in bits.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 cmd_valid  input  1  core presents a command.
REQ-007 cmd_ready  output  1  block is able to accept a command.
REQ-008 cmd_type  input  2  command: 0 = ROM read, 1 = SRAM read, 2 = SRAM write, 3 = reserved.
REQ-009 cmd_rom_addr  input  ROM_AW  ROM address.
REQ-010 cmd_sram_addr  input  SRAM_AW  SRAM address.
REQ-011 cmd_wdata  input  DW  SRAM write data.
REQ-012 done  output  1  one-cycle pulse when a command completes.
REQ-013 rom_a_o  output  1  serial ROM address pin.
REQ-014 sram_a_o  output  1  serial SRAM address pin.
REQ-015 sram_d_o  output  1  serial SRAM data pin.
REQ-016 sram_wen_o  output  1  SRAM write enable, active-low.
REQ-017 Dtype_o  output  2  active-phase tag: 0 = idle, 1 = ROM addr, 2 = SRAM addr, 3 = SRAM data.

Function
REQ-018 A command SHALL be accepted on a rising edge where cmd_valid and cmd_ready are both 1; all cmd_* fields SHALL be captured on that edge.
REQ-019 cmd_ready SHALL be 1 only in state IDLE.
REQ-020 States SHALL be IDLE, ADDR, DATA, WRITE, DONE. Transitions:
- IDLE->ADDR on accept of type 0/1/2.
- ADDR->DATA after last address bit for type 2; ADDR->DONE for type 0/1.
- DATA->WRITE after last data bit.
- WRITE->DONE.
- DONE->IDLE.
REQ-021 cmd_type 3 SHALL be accepted and SHALL go IDLE->DONE directly, driving no pins.
REQ-022 All pin outputs SHALL be registered; first serial bit SHALL be visible in the cycle after the accepting edge.
REQ-023 ADDR SHALL last exactly ROM_AW cycles (type 0) or SRAM_AW cycles (types 1/2), one bit per cycle, MSB first, on rom_a_o (type 0) or sram_a_o (types 1/2).
REQ-024 Dtype_o SHALL be 1 during ROM ADDR, 2 during SRAM ADDR, 3 during DATA, 0 in every other state.
REQ-025 DATA SHALL last exactly DW cycles, cmd_wdata MSB first on sram_d_o.
REQ-026 sram_wen_o SHALL be 0 for exactly one cycle (WRITE); it SHALL be 1 at all other times.
REQ-027 done SHALL be 1 for exactly the one DONE cycle.
REQ-028 Resulting latency from accept edge to done high: type 0 ROM_AW+1, type 1 SRAM_AW+1, type 2 SRAM_AW+DW+2 cycles.
REQ-029 Inactive serial pins SHALL be driven 0; an active pin SHALL hold its bit for the full cycle.
REQ-030 Bit counter SHALL be sized ceil(log2(max(ROM_AW,SRAM_AW,DW)))+1 bits and SHALL reload at every phase entry; no wrap-around between phases.
REQ-031 Back-to-back commands: the earliest next accept SHALL be the edge ending the IDLE cycle after DONE; cmd_valid held high across DONE SHALL NOT be accepted early.

Reset
REQ-032 Reset SHALL force IDLE at once, regardless of clock. Outputs during and after reset: cmd_ready=1, done=0, Dtype_o=0, rom_a_o=sram_a_o=sram_d_o=0, sram_wen_o=1.
REQ-033 Reset mid-command SHALL abort the transfer with no sram_wen_o pulse and no done.

Configuration
REQ-034 Macro PIN_SER_GUARD_EN defined: one guard cycle with Dtype_o=0 and all serial pins 0 SHALL be inserted between ADDR and DATA (type 2). Type-2 latency becomes SRAM_AW+DW+3; types 0/1 are unchanged.
REQ-035 PIN_SER_GUARD_EN undefined: no guard cycle; DATA SHALL immediately follow ADDR.

Verification
REQ-036 After reset, ROM read addr 7'h55 -> Dtype_o=1 for 7 cycles; rom_a_o=1,0,1,0,1,0,1; done 8 cycles after accept.
REQ-037 SRAM write addr 10'h3A5, data 8'hC3 -> sram_a_o=1110100101 with Dtype_o=2; then sram_d_o=11000011 with Dtype_o=3; then sram_wen_o=0 for one cycle; done at cycle 20.
REQ-038 SRAM read addr 10'h001 -> 10 cycles Dtype_o=2, last bit 1; sram_wen_o stays 1; done at cycle 11.
REQ-039 Reset asserted mid-DATA of a write -> outputs return to reset values asynchronously; no wen pulse or done follows; the next command runs normally.
REQ-040 cmd_valid held high with two queued commands -> second accepted only after DONE+IDLE; cmd_type 3 -> done exactly 1 cycle after accept with Dtype_o=0 throughout.

Source files
------------

// File: rtl/pin_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : pin_serializer
//  Purpose  : Takes one ROM-read, SRAM-read or SRAM-write command from the
//             core and shifts the address and write data out MSB-first on
//             single-bit pins. Each active phase is tagged on Dtype_o. A
//             write ends with a one-cycle active-low write-enable strobe.
//             Every command ends with a one-cycle done pulse.
//  Ports    : clk, reset (async, active-high)
//             cmd_valid / cmd_ready            - command handshake
//             cmd_type, cmd_rom_addr,
//             cmd_sram_addr, cmd_wdata         - command fields
//             done                             - completion pulse
//             rom_a_o, sram_a_o, sram_d_o      - serial pins (0 when idle)
//             sram_wen_o                       - SRAM write enable, active-low
//             Dtype_o                          - phase tag (0/1/2/3)
//  Options  : PIN_SER_GUARD_EN - when defined, one quiet guard cycle is
//             inserted between the address and data phases of a write.
//  Revision : 1.0 - initial release
// ============================================================================
module pin_serializer #(
    parameter int ROM_AW  = 7,
    parameter int SRAM_AW = 10,
    parameter int DW      = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_type,
    input  logic [ROM_AW-1:0]  cmd_rom_addr,
    input  logic [SRAM_AW-1:0] cmd_sram_addr,
    input  logic [DW-1:0]      cmd_wdata,
    output logic               done,
    output logic               rom_a_o,
    output logic               sram_a_o,
    output logic               sram_d_o,
    output logic               sram_wen_o,
    output logic [1:0]         Dtype_o
);

    localparam int AW   = (ROM_AW > SRAM_AW) ? ROM_AW : SRAM_AW;
    localparam int MAXW = (AW > DW) ? AW : DW;
    localparam int CW   = $clog2(MAXW) + 1;

    localparam logic [1:0] C_ROM_RD  = 2'd0;
    localparam logic [1:0] C_SRAM_WR = 2'd2;
    localparam logic [1:0] C_RSVD    = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4,
        S_GUARD = 3'd5
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [1:0]     type_q, type_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [DW-1:0]  data_q, data_d;

    logic           done_q, done_d;
    logic           rom_a_q, rom_a_d;
    logic           sram_a_q, sram_a_d;
    logic           sram_d_q, sram_d_d;
    logic           wen_q, wen_d;
    logic [1:0]     dtype_q, dtype_d;

    logic           accept;
    logic           is_rom_d;

    assign cmd_ready = (state_q == S_IDLE);
    assign accept    = cmd_valid & cmd_ready;

    // Next-state, bit counter and shift registers. The counter holds the
    // number of bits still to show in the current phase, including the one
    // on the pin now, so a phase ends when it reads 1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        type_d  = type_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    type_d = cmd_type;
                    data_d = cmd_wdata;
                    if (cmd_type == C_RSVD) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ADDR;
                        // Left-align the address so the pin always takes the MSB.
                        if (cmd_type == C_ROM_RD) begin
                            addr_d = AW'(cmd_rom_addr) << (AW - ROM_AW);
                            cnt_d  = CW'(ROM_AW);
                        end else begin
                            addr_d = AW'(cmd_sram_addr) << (AW - SRAM_AW);
                            cnt_d  = CW'(SRAM_AW);
                        end
                    end
                end
            end
            S_ADDR: begin
                if (cnt_q == CW'(1)) begin
                    if (type_q == C_SRAM_WR) begin
`ifdef PIN_SER_GUARD_EN
                        state_d = S_GUARD;
`else
                        state_d = S_DATA;
                        cnt_d   = CW'(DW);
`endif
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    addr_d = addr_q << 1;
                    cnt_d  = cnt_q - CW'(1);
                end
            end
            S_GUARD: begin
                state_d = S_DATA;
                cnt_d   = CW'(DW);
            end
            S_DATA: begin
                if (cnt_q == CW'(1)) begin
                    state_d = S_WRITE;
                end else begin
                    data_d = data_q << 1;
                    cnt_d  = cnt_q - CW'(1);
                end
            end
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Pin values are derived from the next state so that the output flops
    // present each bit in the same cycle as the state it belongs to.
    always_comb begin
        is_rom_d = (type_d == C_ROM_RD);
        rom_a_d  = 1'b0;
        sram_a_d = 1'b0;
        sram_d_d = 1'b0;
        dtype_d  = 2'd0;
        wen_d    = (state_d != S_WRITE);
        done_d   = (state_d == S_DONE);
        if (state_d == S_ADDR) begin
            if (is_rom_d) begin
                rom_a_d = addr_d[AW-1];
                dtype_d = 2'd1;
            end else begin
                sram_a_d = addr_d[AW-1];
                dtype_d  = 2'd2;
            end
        end else if (state_d == S_DATA) begin
            sram_d_d = data_d[DW-1];
            dtype_d  = 2'd3;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            type_q   <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            done_q   <= 1'b0;
            rom_a_q  <= 1'b0;
            sram_a_q <= 1'b0;
            sram_d_q <= 1'b0;
            wen_q    <= 1'b1;
            dtype_q  <= 2'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            type_q   <= type_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            done_q   <= done_d;
            rom_a_q  <= rom_a_d;
            sram_a_q <= sram_a_d;
            sram_d_q <= sram_d_d;
            wen_q    <= wen_d;
            dtype_q  <= dtype_d;
        end
    end

    assign done       = done_q;
    assign rom_a_o    = rom_a_q;
    assign sram_a_o   = sram_a_q;
    assign sram_d_o   = sram_d_q;
    assign sram_wen_o = wen_q;
    assign Dtype_o    = dtype_q;

endmodule
`default_nettype wire

// File: tb/tb_pin_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pin_serializer
//  Purpose  : Self-checking bench for pin_serializer. A queue-based model
//             expands every accepted command into its expected per-cycle
//             output pattern. The DUT is compared against it on every cycle.
//             Directed cases pin the model with hand-computed values.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pin_serializer;

    localparam int ROM_AW  = 7;
    localparam int SRAM_AW = 10;
    localparam int DW      = 8;
`ifdef PIN_SER_GUARD_EN
    localparam int GUARD = 1;
`else
    localparam int GUARD = 0;
`endif

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic [1:0]         cmd_type = 2'd0;
    logic [ROM_AW-1:0]  cmd_rom_addr = '0;
    logic [SRAM_AW-1:0] cmd_sram_addr = '0;
    logic [DW-1:0]      cmd_wdata = '0;
    logic               done;
    logic               rom_a_o;
    logic               sram_a_o;
    logic               sram_d_o;
    logic               sram_wen_o;
    logic [1:0]         Dtype_o;

    pin_serializer #(.ROM_AW(ROM_AW), .SRAM_AW(SRAM_AW), .DW(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_type     (cmd_type),
        .cmd_rom_addr (cmd_rom_addr),
        .cmd_sram_addr(cmd_sram_addr),
        .cmd_wdata    (cmd_wdata),
        .done         (done),
        .rom_a_o      (rom_a_o),
        .sram_a_o     (sram_a_o),
        .sram_d_o     (sram_d_o),
        .sram_wen_o   (sram_wen_o),
        .Dtype_o      (Dtype_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Output vector: ready, done, dtype, rom_a, sram_a, sram_d, wen
    typedef struct packed {
        logic       rdy;
        logic       dn;
        logic [1:0] dt;
        logic       ra;
        logic       sa;
        logic       sd;
        logic       wen;
    } ov_t;

    function automatic ov_t mk(input logic rdy, input logic dn, input logic [1:0] dt,
                               input logic ra, input logic sa, input logic sd, input logic wen);
        ov_t v;
        v.rdy = rdy; v.dn = dn; v.dt = dt; v.ra = ra; v.sa = sa; v.sd = sd; v.wen = wen;
        return v;
    endfunction

    ov_t idle_ov;
    ov_t cur;
    ov_t exp_q[$];

    // Expand a command into the outputs expected on each following cycle.
    task automatic push_cmd(input logic [1:0] t, input logic [ROM_AW-1:0] ra,
                            input logic [SRAM_AW-1:0] sa, input logic [DW-1:0] wd);
        if (t == 2'd0) begin
            for (int i = ROM_AW - 1; i >= 0; i--)
                exp_q.push_back(mk(1'b0, 1'b0, 2'd1, ra[i], 1'b0, 1'b0, 1'b1));
        end else if (t != 2'd3) begin
            for (int i = SRAM_AW - 1; i >= 0; i--)
                exp_q.push_back(mk(1'b0, 1'b0, 2'd2, 1'b0, sa[i], 1'b0, 1'b1));
            if (t == 2'd2) begin
                for (int g = 0; g < GUARD; g++)
                    exp_q.push_back(mk(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1));
                for (int i = DW - 1; i >= 0; i--)
                    exp_q.push_back(mk(1'b0, 1'b0, 2'd3, 1'b0, 1'b0, wd[i], 1'b1));
                exp_q.push_back(mk(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
            end
        end
        exp_q.push_back(mk(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1));
    endtask

    // Model: advances one cycle per rising edge; reset wipes it immediately.
    initial begin
        idle_ov = mk(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        cur = idle_ov;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                exp_q.delete();
                cur = idle_ov;
            end else begin
                if (cmd_valid && cur.rdy)
                    push_cmd(cmd_type, cmd_rom_addr, cmd_sram_addr, cmd_wdata);
                if (exp_q.size() != 0) cur = exp_q.pop_front();
                else cur = idle_ov;
            end
        end
    end

    // Per-cycle comparison against the model, mid-cycle.
    always @(negedge clk) begin
        check("outputs", 32'({cmd_ready, done, Dtype_o, rom_a_o, sram_a_o, sram_d_o, sram_wen_o}),
              32'(cur));
    end

    // Issue one command and observe it until done (bounded).
    task automatic run_cmd(input logic [1:0] t, input logic [ROM_AW-1:0] ra,
                           input logic [SRAM_AW-1:0] sa, input logic [DW-1:0] wd,
                           output int lat, output logic [15:0] ab, output logic [7:0] db,
                           output int wl, output int act);
        int n;
        @(negedge clk);
        cmd_type = t; cmd_rom_addr = ra; cmd_sram_addr = sa; cmd_wdata = wd;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("ready_timeout", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        lat = 0; ab = '0; db = '0; wl = 0; act = 0;
        do begin
            @(negedge clk);
            lat++;
            if (Dtype_o == 2'd1) ab = {ab[14:0], rom_a_o};
            if (Dtype_o == 2'd2) ab = {ab[14:0], sram_a_o};
            if (Dtype_o == 2'd3) db = {db[6:0], sram_d_o};
            if (Dtype_o != 2'd0) act++;
            if (!sram_wen_o) wl++;
        end while (!done && lat < 100);
    endtask

    initial begin
        int lat, wl, act, n, d1, d2;
        logic [15:0] ab;
        logic [7:0]  db;
        logic [3:0]  dn_v, rd_v;

        repeat (2) @(negedge clk);
        check("rst_state", 32'({cmd_ready, done, Dtype_o, rom_a_o, sram_a_o, sram_d_o, sram_wen_o}),
              32'b1_0_00_0_0_0_1);
        reset = 1'b0;

        // ROM read of 7'h55
        run_cmd(2'd0, 7'h55, '0, '0, lat, ab, db, wl, act);
        check("rom_latency", 32'(lat), 32'd8);
        check("rom_bits", 32'(ab[6:0]), 32'b1010101);
        check("rom_active", 32'(act), 32'd7);

        // SRAM write of 8'hC3 to 10'h3A5
        run_cmd(2'd2, '0, 10'h3A5, 8'hC3, lat, ab, db, wl, act);
        check("wr_latency", 32'(lat), 32'(20 + GUARD));
        check("wr_abits", 32'(ab[9:0]), 32'b1110100101);
        check("wr_dbits", 32'(db), 32'hC3);
        check("wr_wen_cycles", 32'(wl), 32'd1);

        // SRAM read of 10'h001
        run_cmd(2'd1, '0, 10'h001, '0, lat, ab, db, wl, act);
        check("rd_latency", 32'(lat), 32'd11);
        check("rd_abits", 32'(ab[9:0]), 32'h001);
        check("rd_wen_cycles", 32'(wl), 32'd0);

        // Reserved type
        run_cmd(2'd3, '0, '0, '0, lat, ab, db, wl, act);
        check("rsvd_latency", 32'(lat), 32'd1);
        check("rsvd_active", 32'(act), 32'd0);

        // Reserved commands back to back with valid held high
        @(negedge clk);
        cmd_type = 2'd3; cmd_valid = 1'b1;
        dn_v = '0; rd_v = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            dn_v = {dn_v[2:0], done};
            rd_v = {rd_v[2:0], cmd_ready};
        end
        cmd_valid = 1'b0;
        check("b2b_done_pattern", 32'(dn_v), 32'b1010);
        check("b2b_ready_pattern", 32'(rd_v), 32'b0101);

        // ROM read followed by a queued reserved command
        @(negedge clk);
        cmd_type = 2'd0; cmd_rom_addr = 7'($urandom); cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_type = 2'd3;
        n = 0; d1 = 0; d2 = 0;
        while (d2 == 0 && n < 40) begin
            @(negedge clk);
            n++;
            if (done) begin
                if (d1 == 0) d1 = n;
                else d2 = n;
            end
        end
        cmd_valid = 1'b0;
        check("queued_first_done", 32'(d1), 32'(ROM_AW + 1));
        check("queued_second_done", 32'(d2), 32'(ROM_AW + 3));

        // Reset in the middle of a write's data phase
        @(negedge clk);
        cmd_type = 2'd2; cmd_sram_addr = 10'($urandom); cmd_wdata = 8'($urandom);
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        n = 0;
        while (Dtype_o != 2'd3 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("reach_data_phase", 32'(Dtype_o), 32'd3);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst_async", 32'({cmd_ready, done, Dtype_o, rom_a_o, sram_a_o, sram_d_o, sram_wen_o}),
              32'b1_0_00_0_0_0_1);
        @(negedge clk);
        reset = 1'b0;
        wl = 0; d1 = 0;
        repeat (30) begin
            @(negedge clk);
            if (!sram_wen_o) wl++;
            if (done) d1++;
        end
        check("abort_no_wen", 32'(wl), 32'd0);
        check("abort_no_done", 32'(d1), 32'd0);

        run_cmd(2'd1, '0, 10'($urandom), '0, lat, ab, db, wl, act);
        check("post_reset_rd_latency", 32'(lat), 32'd11);

        // Random traffic, checked cycle by cycle against the model
        repeat (600) begin
            @(negedge clk);
            cmd_valid     = ($urandom_range(0, 2) != 0);
            cmd_type      = 2'($urandom_range(0, 3));
            cmd_rom_addr  = 7'($urandom);
            cmd_sram_addr = 10'($urandom);
            cmd_wdata     = 8'($urandom);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (40) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
